// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus memory-port arbiter: bus request/response
// structs, arbiter states and the fixed ibus access size.
package mem_bus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } mem_req_t;

    typedef struct packed {
        logic        ready;
        logic [63:0] data;
    } mem_resp_t;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_BUSY_I,
        ARB_BUSY_D,
        ARB_RESP_I,
        ARB_RESP_D
    } arb_state_t;

    localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

    // Instruction words are 32-bit; addr[2] picks the half of the 64-bit beat.
    function automatic logic [31:0] ibus_word(input logic [63:0] beat, input logic hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_starve_counter.sv
// Saturating count of dbus grants made while ibus was waiting; sat forces
// the next grant to ibus.
module mem_bus_arbiter_starve_counter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sat = (cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-beat arbiter sharing one memory port between ibus and dbus; dbus has
// priority, bounded by a starvation counter that eventually forces ibus.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output mem_req_t   mreq,
    input  mem_resp_t  mresp
);

    arb_state_t  state_q, state_d;
    mem_req_t    mreq_q, mreq_d;
    logic [63:0] rdata_q, rdata_d;
    logic        ihi_q, ihi_d;
    logic        sat, force_i, cnt_inc, cnt_clr;

    mem_bus_arbiter_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .sat (sat)
    );

    assign force_i = ireq.valid && sat;

    always_comb begin
        state_d = state_q;
        mreq_d  = mreq_q;
        rdata_d = rdata_q;
        ihi_d   = ihi_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (dreq.valid && !force_i) begin
                    mreq_d.valid    = 1'b1;
                    mreq_d.is_write = |dreq.strobe;
                    mreq_d.addr     = dreq.addr;
                    mreq_d.size     = dreq.size;
                    mreq_d.strobe   = dreq.strobe;
                    mreq_d.data     = dreq.data;
                    cnt_inc         = ireq.valid;
                    cnt_clr         = !ireq.valid;
                    state_d         = ARB_BUSY_D;
                end else if (ireq.valid) begin
                    mreq_d.valid    = 1'b1;
                    mreq_d.is_write = 1'b0;
                    mreq_d.addr     = ireq.addr;
                    mreq_d.size     = MEM_SIZE_WORD;
                    mreq_d.strobe   = '0;
                    mreq_d.data     = '0;
                    ihi_d           = ireq.addr[2];
                    cnt_clr         = 1'b1;
                    state_d         = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                // Request fields stay frozen until memory accepts the beat.
                if (mresp.ready) begin
                    rdata_d      = mresp.data;
                    mreq_d.valid = 1'b0;
                    state_d      = (state_q == ARB_BUSY_I) ? ARB_RESP_I : ARB_RESP_D;
                end
            end
            ARB_RESP_I, ARB_RESP_D: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            mreq_q  <= '0;
            rdata_q <= '0;
            ihi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mreq_q  <= mreq_d;
            rdata_q <= rdata_d;
            ihi_q   <= ihi_d;
        end
    end

    assign mreq          = mreq_q;
    assign iresp.addr_ok = (state_q == ARB_RESP_I);
    assign iresp.data_ok = (state_q == ARB_RESP_I);
    assign iresp.data    = ibus_word(rdata_q, ihi_q);
    assign dresp.addr_ok = (state_q == ARB_RESP_D);
    assign dresp.data_ok = (state_q == ARB_RESP_D);
    assign dresp.data    = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: grant decisions and responses are
// predicted from the arbitration rules and compared by a negedge monitor.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int SL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mem_req_t   mreq;
    mem_resp_t  mresp;

    mem_bus_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .rst   (rst),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .mreq  (mreq),
        .mresp (mresp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        bit          is_i;
        logic [63:0] data;
        bit          wr;
    } exp_t;

    exp_t        expq[$];
    exp_t        e;
    bit          prev_rst = 1'b1;
    bit          prev_idle = 1'b0;
    bit          prev_iv, prev_dv, prev_mvalid, prev_ready;
    logic [63:0] prev_iaddr, cur_iaddr;
    dbus_req_t   prev_d;
    mem_req_t    prev_mreq;
    bit          ok_due = 1'b0;
    bit          cur_is_i, win_d;
    int          starve = 0;

    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_mvalid", 160'(mreq.valid), 160'(0));
            chk("rst_ok", 160'({iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok}), 160'(0));
            chk("rst_mfields", 160'({mreq.is_write, mreq.addr, mreq.size, mreq.strobe, mreq.data}), 160'(0));
            chk("rst_rdata", 160'({iresp.data, dresp.data}), 160'(0));
            starve = 0;
            expq.delete();
            ok_due = 1'b0;
        end else begin
            chk("iresp_ok_pair", 160'(iresp.addr_ok), 160'(iresp.data_ok));
            chk("dresp_ok_pair", 160'(dresp.addr_ok), 160'(dresp.data_ok));
            if (ok_due && expq.size() > 0) begin
                e = expq.pop_front();
                chk("ok_target", 160'({iresp.data_ok, dresp.data_ok}), e.is_i ? 160'(2'b10) : 160'(2'b01));
                if (e.is_i) chk("iresp_data", 160'(iresp.data), 160'(e.data));
                else if (!e.wr) chk("dresp_data", 160'(dresp.data), 160'(e.data));
            end else begin
                chk("spurious_ok", 160'({iresp.data_ok, dresp.data_ok}), 160'(0));
            end
            ok_due = 1'b0;

            if (prev_idle) begin
                chk("grant_valid", 160'(mreq.valid), 160'(prev_iv | prev_dv));
                if (prev_iv || prev_dv) begin
                    win_d = prev_dv && !(prev_iv && starve == SL);
                    if (win_d) begin
                        chk("dbus_fields", 160'({mreq.is_write, mreq.addr, mreq.size, mreq.strobe, mreq.data}),
                            160'({|prev_d.strobe, prev_d.addr, prev_d.size, prev_d.strobe, prev_d.data}));
                        starve = prev_iv ? ((starve < SL) ? starve + 1 : starve) : 0;
                    end else begin
                        chk("ibus_fields", 160'({mreq.is_write, mreq.addr, mreq.size, mreq.strobe}),
                            160'({1'b0, prev_iaddr, 3'b010, 8'h00}));
                        starve = 0;
                        cur_iaddr = prev_iaddr;
                    end
                    cur_is_i = !win_d;
                end
            end else if (prev_mvalid && !prev_ready) begin
                chk("mreq_hold", 160'(mreq), 160'(prev_mreq));
            end else begin
                chk("mreq_quiet", 160'(mreq.valid), 160'(0));
            end

            if (mreq.valid && mresp.ready) begin
                e.is_i = cur_is_i;
                e.wr   = mreq.is_write;
                e.data = cur_is_i ? (cur_iaddr[2] ? {32'h0, mresp.data[63:32]} : {32'h0, mresp.data[31:0]})
                                  : mresp.data;
                expq.push_back(e);
                ok_due = 1'b1;
            end
        end
        prev_idle   = !mreq.valid && !iresp.data_ok && !dresp.data_ok;
        prev_iv     = ireq.valid;
        prev_dv     = dreq.valid;
        prev_iaddr  = ireq.addr;
        prev_d      = dreq;
        prev_mvalid = mreq.valid;
        prev_ready  = mresp.ready;
        prev_mreq   = mreq;
        prev_rst    = rst;
    end

    // ---------------- stimulus and memory model ----------------
    bit          i_wait = 1'b0, d_wait = 1'b0, i_ok, d_ok;
    bit          mem_active = 1'b0, mem_fix = 1'b0;
    logic [63:0] mem_fix_data;
    int          mem_cfg = 0, mem_left = 0;

    task automatic tick();
        @(negedge clk);
        i_ok = iresp.data_ok;
        d_ok = dresp.data_ok;
        @(posedge clk);
        #1;
        if (i_ok) begin i_wait = 1'b0; ireq.valid = 1'b0; end
        if (d_ok) begin d_wait = 1'b0; dreq.valid = 1'b0; end
        if (mreq.valid) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_left   = (mem_cfg < 0) ? int'($urandom_range(0, 3)) : mem_cfg;
            end
            mresp.ready = (mem_left == 0);
            if (mem_left != 0) mem_left--;
        end else begin
            mem_active  = 1'b0;
            mresp.ready = 1'b0;
        end
        mresp.data = mem_fix ? mem_fix_data : {$urandom, $urandom};
    endtask

    task automatic issue_i(input logic [63:0] addr);
        ireq.valid = 1'b1;
        ireq.addr  = addr;
        i_wait     = 1'b1;
    endtask

    task automatic issue_d(input logic [63:0] addr, input logic [2:0] size,
                           input logic [7:0] strobe, input logic [63:0] data);
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = size;
        dreq.strobe = strobe;
        dreq.data   = data;
        d_wait      = 1'b1;
    endtask

    task automatic issue_d_rand();
        logic [7:0] s;
        s = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
        issue_d({$urandom, $urandom}, 3'($urandom_range(0, 3)), s, {$urandom, $urandom});
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && (i_wait || d_wait); k++) tick();
        if (i_wait || d_wait) begin
            $display("FAIL timeout: outstanding i=%0d d=%0d expected none", i_wait, d_wait);
            $fatal(1, "bench timeout");
        end
    endtask

    initial begin
        ireq  = '0;
        dreq  = '0;
        mresp = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // ibus alone, minimum latency, high word selected by addr[2]
        mem_cfg = 0; mem_fix = 1'b1; mem_fix_data = 64'hDEADBEEF_12345678;
        issue_i(64'h8000_0004);
        wait_done();
        mem_fix = 1'b0;
        tick();

        // simultaneous requests: dbus write first, then ibus
        issue_i(64'h0000_1000);
        issue_d(64'h100, 3'b011, 8'hFF, {$urandom, $urandom});
        wait_done();
        tick();

        // dbus kept busy while ibus waits: ibus must win the 9th grant
        mem_cfg = -1;
        issue_i(64'h0000_2008);
        for (int k = 0; k < 300 && i_wait; k++) begin
            if (!d_wait) issue_d_rand();
            tick();
        end
        wait_done();
        tick();

        // memory stalls five cycles on a dbus read
        mem_cfg = 5;
        issue_d(64'h0000_0200, 3'b011, 8'h00, 64'h0);
        wait_done();
        tick();

        // reset while ibus is in flight
        mem_cfg = 10;
        issue_i(64'h0000_3000);
        tick(); tick();
        rst = 1'b1; ireq.valid = 1'b0; i_wait = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        mem_cfg = 1;
        issue_i(64'h0000_3004);
        wait_done();
        tick();

        // ibus drops valid mid-transaction, response still due
        mem_cfg = 3;
        issue_i(64'h0000_4000);
        tick(); tick();
        ireq.valid = 1'b0;
        wait_done();
        tick();

        // random traffic
        mem_cfg = -1;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!i_wait && $urandom_range(0, 2) == 0) issue_i({$urandom, $urandom});
            if (!d_wait && $urandom_range(0, 2) == 0) issue_d_rand();
        end
        wait_done();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
